// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: status FSM
// encodings and the state register width.
package fifo_pkg;

    localparam int STATE_W = 3;

    // Status FSM encodings; the state records the operation done at the last edge.
    typedef enum logic [STATE_W-1:0] {
        ST_INIT     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_READ     = 3'd2,
        ST_WR_ERROR = 3'd3,
        ST_RD_ERROR = 3'd4,
        ST_NO_OP    = 3'd5,
        ST_WR_RD    = 3'd6
    } state_t;

endpackage : fifo_pkg

// File: rtl/fifo_sync_param_ns.sv
// Combinational accept logic and status FSM next-state decode.
// Accept decisions use the pre-edge full/empty flags.
module fifo_sync_param_ns
    import fifo_pkg::*;
(
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic               full,
    input  logic               empty,
    input  logic [STATE_W-1:0] state,
    output state_t             next_state,
    output logic               wr_ok,
    output logic               rd_ok
);

    logic state_legal;

    // Accept rules and prioritised next-state selection.
    always_comb begin
        // A full FIFO can still take a write when a real read frees a slot
        // in the same cycle; reads never bypass a concurrent write.
        wr_ok       = wr_en && (!full || (rd_en && !empty));
        rd_ok       = rd_en && !empty;
        state_legal = (state <= STATE_W'(ST_WR_RD));
        next_state  = ST_NO_OP;
        if (!state_legal) begin
            // The one unused encoding falls back to an idle report.
            next_state = ST_NO_OP;
        end else if (wr_ok && rd_ok) begin
            next_state = ST_WR_RD;
        end else if (wr_en && !wr_ok) begin
            next_state = ST_WR_ERROR;
        end else if (rd_en && !rd_ok) begin
            next_state = ST_RD_ERROR;
        end else if (wr_ok) begin
            next_state = ST_WRITE;
        end else if (rd_ok) begin
            next_state = ST_READ;
        end
    end

endmodule : fifo_sync_param_ns

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with arbitrary depth, simultaneous read/write,
// programmable almost flags, per-edge ack/err pulses and a status FSM.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 8,
    parameter  int AF_LEVEL   = DEPTH - 1,
    parameter  int AE_LEVEL   = 1,
    localparam int CNT_W      = $clog2(DEPTH + 1),
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CNT_W-1:0]      data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [STATE_W-1:0]    state
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] dout_reg;
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  wr_ack_reg, wr_err_reg, rd_ack_reg, rd_err_reg;
    state_t                state_reg, state_next;
    logic                  wr_ok, rd_ok;

    fifo_sync_param_ns u_ns (
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .full       (full),
        .empty      (empty),
        .state      (state_reg),
        .next_state (state_next),
        .wr_ok      (wr_ok),
        .rd_ok      (rd_ok)
    );

    // Pointer wrap is an explicit compare so non-power-of-2 depths work.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (wr_ok) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
    end

    // Occupancy moves only when exactly one side of the transfer happens.
    always_comb begin
        count_next = count_reg;
        if (wr_ok && !rd_ok) begin
            count_next = count_reg + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok && !reset) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Registered read port; dout holds when no read is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_reg <= '0;
        end else if (rd_ok) begin
            dout_reg <= mem[rd_ptr_reg];
        end
    end

    // Pointers, count, status FSM and the one-cycle ack/err pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= ST_INIT;
            wr_ack_reg <= 1'b0;
            wr_err_reg <= 1'b0;
            rd_ack_reg <= 1'b0;
            rd_err_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            state_reg  <= state_next;
            wr_ack_reg <= wr_ok;
            wr_err_reg <= wr_en && !wr_ok;
            rd_ack_reg <= rd_ok;
            rd_err_reg <= rd_en && !rd_ok;
        end
    end

    assign dout         = dout_reg;
    assign data_count   = count_reg;
    assign full         = (count_reg == CNT_W'(DEPTH));
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_reg <= CNT_W'(AE_LEVEL));
    assign wr_ack       = wr_ack_reg;
    assign wr_err       = wr_err_reg;
    assign rd_ack       = rd_ack_reg;
    assign rd_err       = rd_err_reg;
    assign state        = state_reg;

endmodule : fifo_sync_param

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Single-clock synchronous FIFO with parametrised data width and depth, plus an operation-status FSM.
- Generalises the team's fixed 8-entry FIFO status FSM.
- New capabilities: simultaneous read+write in one cycle, non-power-of-2 depth, and programmable almost-full/almost-empty flags.
- Sits between any producer/consumer pair in the same clock domain.

Parameters:
- DATA_WIDTH, 32, width of din/dout.
- DEPTH, 8, number of entries; any integer >= 2, not necessarily a power of 2.
- AF_LEVEL, DEPTH-1, almost_full asserts when data_count >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when data_count <= AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  registered read data.
- data_count  out  CNT_W=$clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full  out  1  data_count==DEPTH.
- empty  out  1  data_count==0.
- almost_full  out  1  see AF_LEVEL.
- almost_empty  out  1  see AE_LEVEL.
- wr_ack  out  1  previous edge performed a write.
- wr_err  out  1  previous edge rejected a write.
- rd_ack  out  1  previous edge performed a read; dout valid.
- rd_err  out  1  previous edge rejected a read.
- state  out  3  status FSM state.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset; sampled only on the rising edge of clk.
- Reset values:
  - wr_ptr=rd_ptr=0, data_count=0, dout=0, state=INIT.
  - empty=1, almost_empty=1, full=0, almost_full=0 (unless AF_LEVEL==0).
  - All ack/err=0.
  - Memory contents are not reset.
- Accept rules, evaluated on current (pre-edge) data_count:
  - wr_ok = wr_en & (!full | (rd_en & !empty)). A write into a full FIFO succeeds only when paired with a successful read.
  - rd_ok = rd_en & !empty. No bypass: a read on an empty FIFO errors even if a write is concurrent.
- Write: when wr_ok, mem[wr_ptr]<=din and wr_ptr advances.
- Read: when rd_ok, dout<=mem[rd_ptr] and rd_ptr advances. Read latency is 1 cycle: dout and rd_ack are valid in the cycle after rd_en is sampled. dout holds its value when no read occurs.
- Pointer wrap: ptr==DEPTH-1 -> 0. Explicit compare, never relies on natural binary overflow. PTR_W=$clog2(DEPTH).
- Count update:
  - +1 on wr_ok & !rd_ok.
  - -1 on rd_ok & !wr_ok.
  - Unchanged when both or neither.
  - Never exceeds DEPTH or underflows 0.
- Flags full/empty/almost_* are combinational from the registered data_count.
- Status FSM: registered; the state records the operation performed at the last edge.
- States (3-bit): INIT=0, WRITE=1, READ=2, WR_ERROR=3, RD_ERROR=4, NO_OP=5, WR_RD=6. Value 7 is unused and recovers to NO_OP.
- Next-state, same from every state including INIT; priority top-down:
  - wr_ok & rd_ok -> WR_RD.
  - wr_en & !wr_ok -> WR_ERROR.
  - rd_en & !rd_ok -> RD_ERROR. When both requests fail (impossible by the rules), WR_ERROR takes priority.
  - wr_ok -> WRITE.
  - rd_ok -> READ.
  - else -> NO_OP.
- Mixed outcome (write accepted, read rejected on empty): state=RD_ERROR, and both wr_ack and rd_err assert.
- Outputs wr_ack/wr_err/rd_ack/rd_err are registered one-cycle pulses reflecting the last edge. They are independent of state priority, so both a write flag and a read flag may be high at once.
- INIT is left on the first non-reset edge and never re-entered except by reset.
- Reset mid-operation: all requests in the reset cycle are ignored, pointers and count clear, and there is no ack/err pulse afterwards.

Decomposition:
- Package fifo_pkg: state encodings (INIT..WR_RD), the state width constant (3), and a function clog2 if the toolchain lacks $clog2.
- Sub-module fifo_sync_param_ns: purely combinational next-state logic. Inputs wr_en, rd_en, full, empty, state. Outputs next_state, wr_ok, rd_ok.
- Top module holds the memory array, pointers, count, dout, and the flag registers.

Test Plan:
- Reset, DEPTH=8 -> data_count=0, empty=1, almost_empty=1, state=INIT. First idle cycle -> state=NO_OP.
- Write 0xA0..0xA7 (8 writes), then 1 extra write -> data_count=8, full=1. Extra write gives wr_err=1, state=WR_ERROR, count stays 8. Drain 8 reads -> dout 0xA0..0xA7 in order, each one cycle after rd_en.
- Read on empty -> rd_err=1, state=RD_ERROR, dout unchanged. Then wr_en=rd_en=1 on empty with din=0x55 -> wr_ack=1, rd_err=1, data_count=1. Next read returns 0x55.
- Full FIFO, wr_en=rd_en=1 with din=0x99 -> state=WR_RD, wr_ack=rd_ack=1, count stays 8, dout=oldest entry. 0x99 is read out last.
- DEPTH=5, AF_LEVEL=4, AE_LEVEL=1: 12 writes interleaved with reads -> pointers wrap 4->0, data order preserved, almost_full at count 4, almost_empty at count <=1.
- Assert reset during a streaming burst at count=3 -> next cycle count=0, empty=1, state=INIT, no ack/err pulses.
